noc_axilite_resp: RTL and testbench



---
 rtl/noc_axilite_resp.sv | 143 ++++++++++++++
 tb/tb_noc_axilite_resp.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_axilite_resp.sv
// noc_axilite_resp: turns NoC3 NC load/store memory acks into AXI-lite R/B beats.
// Optional: define NOC_AXILITE_RESP_DROP_CNT_EN to expose the drop_cnt counter.
module noc_axilite_resp #(
    parameter int AXI_LITE_DATA_WIDTH = 512
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           noc3_valid_in,
    input  logic [63:0]                    noc3_data_in,
    output logic                           noc3_ready_out,
    output logic [AXI_LITE_DATA_WIDTH-1:0] m_axi_rdata,
    output logic [1:0]                     m_axi_rresp,
    output logic                           m_axi_rvalid,
    input  logic                           m_axi_rready,
    output logic [1:0]                     m_axi_bresp,
    output logic                           m_axi_bvalid,
    input  logic                           m_axi_bready
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
    ,
    output logic [15:0]                    drop_cnt
`endif
);

    localparam logic [7:0] MSG_TYPE_NC_LOAD_MEM_ACK  = 8'd26;
    localparam logic [7:0] MSG_TYPE_NC_STORE_MEM_ACK = 8'd27;
    localparam int NOC_PAYLOAD_LEN =
        (AXI_LITE_DATA_WIDTH / 64 > 1) ? AXI_LITE_DATA_WIDTH / 64 : 1;
    localparam int BUF_W = NOC_PAYLOAD_LEN * 64;

    typedef enum logic [1:0] {HDR, DATA, DISCARD} state_t;

    state_t           state;
    logic [7:0]       cnt;
    logic [7:0]       len;
    logic             disc_store;
    logic [BUF_W-1:0] rbuf;

    logic [7:0] hdr_type;
    logic [7:0] hdr_len;
    logic       hdr_is_load;
    logic       hdr_is_store;
    logic       flit_acc;
    logic       last_flit;

    assign hdr_type     = noc3_data_in[29:22];
    assign hdr_len      = noc3_data_in[21:14];
    assign hdr_is_load  = noc3_valid_in && (hdr_type == MSG_TYPE_NC_LOAD_MEM_ACK);
    assign hdr_is_store = noc3_valid_in && (hdr_type == MSG_TYPE_NC_STORE_MEM_ACK);
    assign flit_acc     = noc3_valid_in && noc3_ready_out;
    assign last_flit    = (cnt == len - 8'd1);

    // Each ack type only waits on its own channel, so R and B never block each other.
    always_comb begin
        noc3_ready_out = 1'b0;
        if (!rst) begin
            unique case (state)
                HDR:     noc3_ready_out = !(hdr_is_load && m_axi_rvalid) &&
                                          !(hdr_is_store && m_axi_bvalid);
                DATA:    noc3_ready_out = 1'b1;
                DISCARD: noc3_ready_out = 1'b1;
                default: noc3_ready_out = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= HDR;
            cnt          <= 8'd0;
            len          <= 8'd0;
            disc_store   <= 1'b0;
            rbuf         <= '0;
            m_axi_rvalid <= 1'b0;
            m_axi_bvalid <= 1'b0;
        end else begin
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (flit_acc) begin
                unique case (state)
                    HDR: begin
                        cnt        <= 8'd0;
                        len        <= hdr_len;
                        disc_store <= 1'b0;
                        unique case (1'b1)
                            hdr_type == MSG_TYPE_NC_LOAD_MEM_ACK: begin
                                rbuf <= '0;
                                if (hdr_len == 8'd0) m_axi_rvalid <= 1'b1;
                                else                 state        <= DATA;
                            end
                            hdr_type == MSG_TYPE_NC_STORE_MEM_ACK: begin
                                if (hdr_len == 8'd0) begin
                                    m_axi_bvalid <= 1'b1;
                                end else begin
                                    state      <= DISCARD;
                                    disc_store <= 1'b1;
                                end
                            end
                            default: begin
                                if (hdr_len != 8'd0) state <= DISCARD;
                            end
                        endcase
                    end
                    DATA: begin
                        for (int i = 0; i < NOC_PAYLOAD_LEN; i++) begin
                            if (cnt == 8'(i)) rbuf[64*i +: 64] <= noc3_data_in;
                        end
                        if (last_flit) begin
                            m_axi_rvalid <= 1'b1;
                            state        <= HDR;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    DISCARD: begin
                        if (last_flit) begin
                            state <= HDR;
                            if (disc_store) m_axi_bvalid <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: state <= HDR;
                endcase
            end
        end
    end

`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 16'd0;
        end else if (flit_acc && state == HDR && !hdr_is_load && !hdr_is_store &&
                     drop_cnt != 16'hFFFF) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

    assign m_axi_rdata = rbuf[AXI_LITE_DATA_WIDTH-1:0];
    assign m_axi_rresp = 2'b00;
    assign m_axi_bresp = 2'b00;

endmodule

// File: tb/tb_noc_axilite_resp.sv
// tb_noc_axilite_resp: random NoC3 ack traffic into three widths of noc_axilite_resp,
// checked every cycle against a message-level model.
module tb_noc_axilite_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        noc3_valid_in;
    logic [63:0] noc3_data_in;
    logic        rready;
    logic        bready;

    logic         rdy_a, rdy_b, rdy_c;
    logic [511:0] rdata_a;
    logic [127:0] rdata_b;
    logic [31:0]  rdata_c;
    logic [1:0]   rresp_a, rresp_b, rresp_c;
    logic [1:0]   bresp_a, bresp_b, bresp_c;
    logic         rvalid_a, rvalid_b, rvalid_c;
    logic         bvalid_a, bvalid_b, bvalid_c;
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
    logic [15:0]  drop_a, drop_b, drop_c;
`endif

    noc_axilite_resp #(.AXI_LITE_DATA_WIDTH(512)) u_a (
        .clk(clk), .rst(rst),
        .noc3_valid_in(noc3_valid_in), .noc3_data_in(noc3_data_in),
        .noc3_ready_out(rdy_a),
        .m_axi_rdata(rdata_a), .m_axi_rresp(rresp_a),
        .m_axi_rvalid(rvalid_a), .m_axi_rready(rready),
        .m_axi_bresp(bresp_a), .m_axi_bvalid(bvalid_a),
        .m_axi_bready(bready)
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
        , .drop_cnt(drop_a)
`endif
    );

    noc_axilite_resp #(.AXI_LITE_DATA_WIDTH(128)) u_b (
        .clk(clk), .rst(rst),
        .noc3_valid_in(noc3_valid_in), .noc3_data_in(noc3_data_in),
        .noc3_ready_out(rdy_b),
        .m_axi_rdata(rdata_b), .m_axi_rresp(rresp_b),
        .m_axi_rvalid(rvalid_b), .m_axi_rready(rready),
        .m_axi_bresp(bresp_b), .m_axi_bvalid(bvalid_b),
        .m_axi_bready(bready)
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
        , .drop_cnt(drop_b)
`endif
    );

    noc_axilite_resp #(.AXI_LITE_DATA_WIDTH(32)) u_c (
        .clk(clk), .rst(rst),
        .noc3_valid_in(noc3_valid_in), .noc3_data_in(noc3_data_in),
        .noc3_ready_out(rdy_c),
        .m_axi_rdata(rdata_c), .m_axi_rresp(rresp_c),
        .m_axi_rvalid(rvalid_c), .m_axi_rready(rready),
        .m_axi_bresp(bresp_c), .m_axi_bvalid(bvalid_c),
        .m_axi_bready(bready)
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
        , .drop_cnt(drop_c)
`endif
    );

    int passed = 0;
    int total  = 0;

    logic [63:0]  fq[$];
    logic [63:0]  pay[$];
    logic [511:0] rq_a[$];
    logic [127:0] rq_b[$];
    logic [31:0]  rq_c[$];
    int           bq = 0;
    int           drops = 0;
    int           rem = 0;
    bit           in_msg = 1'b0;
    logic [7:0]   cur_type;
    bit           post_rst = 1'b1;
    bit           auto_gen = 1'b1;
    int           vprob = 80, rprob = 50, bprob = 50;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
    endtask

    task automatic gen_msg(input logic [7:0] t, input int l);
        logic [63:0] h;
        h = {$urandom, $urandom};
        h[29:22] = t;
        h[21:14] = 8'(l);
        fq.push_back(h);
        for (int i = 0; i < l; i++) fq.push_back({$urandom, $urandom});
    endtask

    task automatic gen_rand();
        logic [7:0] t;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 4)      t = 8'd26;
        else if (sel < 7) t = 8'd27;
        else begin
            t = 8'($urandom_range(0, 255));
            if (t == 8'd26 || t == 8'd27) t = 8'd3;
        end
        gen_msg(t, ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 10));
    endtask

    // Expected rdata is the first flits of the payload laid side by side.
    task automatic finish_msg();
        logic [511:0] a;
        a = '0;
        if (cur_type == 8'd26) begin
            for (int i = 0; i < pay.size() && i < 8; i++) a[64*i +: 64] = pay[i];
            rq_a.push_back(a);
            rq_b.push_back(a[127:0]);
            rq_c.push_back(a[31:0]);
        end else if (cur_type == 8'd27) begin
            bq++;
        end
    endtask

    task automatic accept(input logic [63:0] f);
        if (!in_msg) begin
            cur_type = f[29:22];
            rem = int'(f[21:14]);
            pay.delete();
            if (cur_type != 8'd26 && cur_type != 8'd27 && drops < 65535) drops++;
            if (rem == 0) finish_msg();
            else in_msg = 1'b1;
        end else begin
            pay.push_back(f);
            rem--;
            if (rem == 0) begin
                finish_msg();
                in_msg = 1'b0;
            end
        end
    endtask

    task automatic cycle(input bit rst_now);
        bit hv;
        bit exp_rdy;
        @(negedge clk);
        chk("rvalid_512", rvalid_a, rq_a.size() > 0);
        chk("rvalid_128", rvalid_b, rq_b.size() > 0);
        chk("rvalid_32",  rvalid_c, rq_c.size() > 0);
        chk("bvalid_512", bvalid_a, bq > 0);
        chk("bvalid_128", bvalid_b, bq > 0);
        chk("bvalid_32",  bvalid_c, bq > 0);
        if (rq_a.size() > 0) begin
            chk("rdata_512", rdata_a, rq_a[0]);
            chk("rdata_128", rdata_b, rq_b[0]);
            chk("rdata_32",  rdata_c, rq_c[0]);
            chk("rresp", {rresp_a, rresp_b, rresp_c}, 6'd0);
        end
        if (bq > 0) chk("bresp", {bresp_a, bresp_b, bresp_c}, 6'd0);
        if (post_rst) begin
            chk("rdata_rst", {rdata_a, rdata_b, rdata_c}, '0);
            post_rst = 1'b0;
        end
`ifdef NOC_AXILITE_RESP_DROP_CNT_EN
        chk("drop_cnt_512", drop_a, drops);
        chk("drop_cnt_32",  drop_c, drops);
`endif
        rst    = rst_now;
        rready = ($urandom_range(0, 99) < rprob);
        bready = ($urandom_range(0, 99) < bprob);
        if (fq.size() == 0 && auto_gen) gen_rand();
        hv = (fq.size() > 0) && ($urandom_range(0, 99) < vprob);
        noc3_valid_in = hv;
        noc3_data_in  = hv ? fq[0] : {$urandom, $urandom};
        #1;
        if (rst_now)     exp_rdy = 1'b0;
        else if (in_msg) exp_rdy = 1'b1;
        else exp_rdy = !(hv && fq[0][29:22] == 8'd26 && rq_a.size() > 0) &&
                       !(hv && fq[0][29:22] == 8'd27 && bq > 0);
        chk("ready_512", rdy_a, exp_rdy);
        chk("ready_128", rdy_b, exp_rdy);
        chk("ready_32",  rdy_c, exp_rdy);
        if (rst_now) begin
            fq.delete(); pay.delete();
            rq_a.delete(); rq_b.delete(); rq_c.delete();
            bq = 0; drops = 0; rem = 0; in_msg = 1'b0;
            post_rst = 1'b1;
        end else begin
            if (rq_a.size() > 0 && rready) begin
                void'(rq_a.pop_front());
                void'(rq_b.pop_front());
                void'(rq_c.pop_front());
            end
            if (bq > 0 && bready) bq--;
            if (hv && exp_rdy) accept(fq.pop_front());
        end
    endtask

    task automatic run(input int n, input int vp, input int rp, input int bp);
        vprob = vp; rprob = rp; bprob = bp;
        for (int i = 0; i < n; i++) cycle(1'b0);
    endtask

    task automatic drain();
        auto_gen = 1'b0;
        for (int i = 0; i < 500 && fq.size() > 0; i++) cycle(1'b0);
        chk("drain", fq.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        noc3_valid_in = 1'b0;
        noc3_data_in = '0;
        rready = 1'b0;
        bready = 1'b0;
        repeat (2) @(posedge clk);
        cycle(1'b1);

        run(800, 80, 50, 50);
        run(600, 100, 100, 100);
        run(800, 90, 10, 10);

        drain();
        vprob = 100; rprob = 50; bprob = 50;
        gen_msg(8'd3, 2);
        gen_msg(8'd26, 8);
        for (int i = 0; i < 200 && !(cur_type == 8'd26 && pay.size() == 3); i++) cycle(1'b0);
        chk("rst_setup", pay.size(), 3);
        cycle(1'b1);
        cycle(1'b0);
        gen_msg(8'd26, 8);
        gen_msg(8'd27, 0);
        drain();
        auto_gen = 1'b1;

        run(800, 70, 60, 40);
        auto_gen = 1'b0;
        run(60, 100, 100, 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
